// File: rtl/alu_core.sv
// Registered integer ALU: one-cycle latency, result plus {N,Z,C,V} status.
// Define ALU_SHIFT_EN to turn op codes 1100-1111 into LSL/LSR/ASR/ROR; otherwise they return zero.
module alu_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic [DATA_WIDTH-1:0] i_A,
  input  logic [DATA_WIDTH-1:0] i_B,
  input  logic [3:0]            i_Sigs_Control,
  input  logic                  i_Sig_Carry_In,
  output logic [DATA_WIDTH-1:0] o_ALU_Result,
  output logic [3:0]            o_Status
);

  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] OP_PASS_A = 4'b0000;
  localparam logic [3:0] OP_PASS_B = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_ADC    = 4'b0011;
  localparam logic [3:0] OP_SUB    = 4'b0100;
  localparam logic [3:0] OP_SBC    = 4'b0101;
  localparam logic [3:0] OP_AND    = 4'b0110;
  localparam logic [3:0] OP_OR     = 4'b0111;
  localparam logic [3:0] OP_XOR    = 4'b1000;
  localparam logic [3:0] OP_NOT_B  = 4'b1001;
  localparam logic [3:0] OP_BIC    = 4'b1010;
  localparam logic [3:0] OP_RSB    = 4'b1011;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_LSL    = 4'b1100;
  localparam logic [3:0] OP_LSR    = 4'b1101;
  localparam logic [3:0] OP_ASR    = 4'b1110;
  localparam logic [3:0] OP_ROR    = 4'b1111;
  localparam int SHW = $clog2(DATA_WIDTH);
`endif

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [3:0]            status_q, status_d;

  logic                  cin_add, cin_sub, is_rsb;
  logic [DATA_WIDTH-1:0] sub_m, sub_s;
  logic [DATA_WIDTH:0]   add_w, sub_w;
  logic                  c_d, v_d;
`ifdef ALU_SHIFT_EN
  logic [SHW-1:0]        sh;
  logic [SHW:0]          rol_amt;
  logic [DATA_WIDTH:0]   lsl_w, lsr_w;
  logic signed [DATA_WIDTH:0] asr_w;
  logic [DATA_WIDTH-1:0] ror_r;
`endif

  always_comb begin
    cin_add = (i_Sigs_Control == OP_ADC) & i_Sig_Carry_In;
    cin_sub = (i_Sigs_Control == OP_SBC) & i_Sig_Carry_In;
    is_rsb  = (i_Sigs_Control == OP_RSB);
    sub_m   = is_rsb ? i_B : i_A;
    sub_s   = is_rsb ? i_A : i_B;
    // One extra bit: add_w[MSB+1] is carry-out, sub_w[MSB+1] is borrow-out.
    add_w   = {1'b0, i_A} + {1'b0, i_B} + {{DATA_WIDTH{1'b0}}, cin_add};
    sub_w   = {1'b0, sub_m} - {1'b0, sub_s} - {{DATA_WIDTH{1'b0}}, cin_sub};
`ifdef ALU_SHIFT_EN
    sh      = i_B[SHW-1:0];
    rol_amt = (SHW+1)'(DATA_WIDTH) - {1'b0, sh};
    // Shifted-out bit is caught in the extra position of each widened operand.
    lsl_w   = {1'b0, i_A} << sh;
    lsr_w   = {i_A, 1'b0} >> sh;
    asr_w   = $signed({i_A, 1'b0}) >>> sh;
    ror_r   = (i_A >> sh) | (i_A << rol_amt);
`endif

    result_d = '0;
    c_d      = 1'b0;
    v_d      = 1'b0;
    case (i_Sigs_Control)
      OP_PASS_A: result_d = i_A;
      OP_PASS_B: result_d = i_B;
      OP_ADD, OP_ADC: begin
        result_d = add_w[MSB:0];
        c_d      = add_w[DATA_WIDTH];
        v_d      = (i_A[MSB] == i_B[MSB]) && (result_d[MSB] != i_A[MSB]);
      end
      OP_SUB, OP_SBC, OP_RSB: begin
        result_d = sub_w[MSB:0];
        c_d      = sub_w[DATA_WIDTH];
        v_d      = (sub_m[MSB] != sub_s[MSB]) && (result_d[MSB] != sub_m[MSB]);
      end
      OP_AND:    result_d = i_A & i_B;
      OP_OR:     result_d = i_A | i_B;
      OP_XOR:    result_d = i_A ^ i_B;
      OP_NOT_B:  result_d = ~i_B;
      OP_BIC:    result_d = i_A & ~i_B;
`ifdef ALU_SHIFT_EN
      OP_LSL: begin
        result_d = lsl_w[MSB:0];
        c_d      = lsl_w[DATA_WIDTH];
      end
      OP_LSR: begin
        result_d = lsr_w[DATA_WIDTH:1];
        c_d      = lsr_w[0];
      end
      OP_ASR: begin
        result_d = asr_w[DATA_WIDTH:1];
        c_d      = asr_w[0];
      end
      OP_ROR: begin
        result_d = ror_r;
        c_d      = (sh != '0) & ror_r[MSB];
      end
`endif
      default: result_d = '0;
    endcase

    status_d = {result_d[MSB], (result_d == '0), c_d, v_d};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      result_q <= '0;
      status_q <= 4'b0000;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign o_ALU_Result = result_q;
  assign o_Status     = status_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vectors plus randomized stream against a behavioural model.
module tb_alu_core;
  localparam int W = 32;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  a = '0, b = '0;
  logic [3:0]    op = '0;
  logic          cin = 1'b0;
  logic [W-1:0]  r;
  logic [3:0]    st;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;
  logic [W+3:0] exp_q = '0;

  alu_core #(.DATA_WIDTH(W)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_A(a), .i_B(b),
    .i_Sigs_Control(op), .i_Sig_Carry_In(cin),
    .o_ALU_Result(r), .o_Status(st)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [3:0] mop, input logic mcin);
    longint ua, ub, sa, sb, full, sv;
    logic [W-1:0] res, t;
    logic c, v;
    int sh;
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    res = '0; c = 1'b0; v = 1'b0; full = 0; sv = 0;
    sh = int'(mb[4:0]);
    case (mop)
      4'd0: res = ma;
      4'd1: res = mb;
      4'd2, 4'd3: begin
        full = ua + ub + ((mop == 4'd3 && mcin) ? 64'd1 : 64'd0);
        sv   = sa + sb + ((mop == 4'd3 && mcin) ? 64'd1 : 64'd0);
        res  = full[W-1:0];
        c    = full > 64'hFFFF_FFFF;
        v    = (sv > SMAX) || (sv < SMIN);
      end
      4'd4, 4'd5: begin
        full = ub + ((mop == 4'd5 && mcin) ? 64'd1 : 64'd0);
        res  = ma - full[W-1:0];
        c    = ua < full;
        sv   = sa - sb - ((mop == 4'd5 && mcin) ? 64'd1 : 64'd0);
        v    = (sv > SMAX) || (sv < SMIN);
      end
      4'd11: begin
        res = mb - ma;
        c   = ub < ua;
        sv  = sb - sa;
        v   = (sv > SMAX) || (sv < SMIN);
      end
      4'd6: res = ma & mb;
      4'd7: res = ma | mb;
      4'd8: res = ma ^ mb;
      4'd9: res = ~mb;
      4'd10: res = ma & ~mb;
`ifdef ALU_SHIFT_EN
      4'd12: begin
        res = ma << sh;
        t = ma >> (W - sh);
        c = (sh != 0) && t[0];
      end
      4'd13, 4'd14, 4'd15: begin
        if (mop == 4'd13) res = ma >> sh;
        else if (mop == 4'd14) res = $signed(ma) >>> sh;
        else res = (ma >> sh) | ((sh == 0) ? '0 : (ma << (W - sh)));
        t = ma >> (sh - 1);
        c = (sh != 0) && t[0];
      end
`endif
      default: res = '0;
    endcase
    return {res, res[W-1], (res == '0), c, v};
  endfunction

  task automatic check(input string name, input logic [W+3:0] act, input logic [W+3:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got R=%h S=%b required R=%h S=%b",
                  name, act[W+3:4], act[3:0], expv[W+3:4], expv[3:0]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q = '0;
    else exp_q = model(a, b, op, cin);
  end

  always @(negedge clk) begin
    if (chk_en) check("stream", {r, st}, exp_q);
  end

  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic [3:0] dop, input logic dcin);
    a = da; b = db; op = dop; cin = dcin;
  endtask

  task automatic directed(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                          input logic [3:0] dop, input logic dcin,
                          input logic [W-1:0] er, input logic [3:0] es);
    check({name, "/model"}, model(da, db, dop, dcin), {er, es});
    drive(da, db, dop, dcin);
    @(posedge clk);
    #1;
    check(name, {r, st}, {er, es});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    #3 rst_n = 1'b0;
    #1 check("reset_async", {r, st}, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {r, st}, '0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    directed("pass_b", 32'hAAAA_AAAA, 32'h5555_5555, 4'b0001, 1'b0, 32'h5555_5555, 4'b0000);
    directed("not_b",  32'hAAAA_AAAA, 32'h5555_5555, 4'b1001, 1'b0, 32'hAAAA_AAAA, 4'b1000);
    directed("pass_a_cin", 32'h1234_5678, 32'h0, 4'b0000, 1'b1, 32'h1234_5678, 4'b0000);
    directed("add",    32'h0000_00A5, 32'h0000_005A, 4'b0010, 1'b0, 32'h0000_00FF, 4'b0000);
    directed("add_cin_ignored", 32'h0000_00A5, 32'h0000_005A, 4'b0010, 1'b1, 32'h0000_00FF, 4'b0000);
    directed("adc",    32'hFFFF_FFFF, 32'h0000_0001, 4'b0011, 1'b1, 32'h0000_0001, 4'b0010);
    directed("sub",    32'h0000_00FF, 32'h0000_00A5, 4'b0100, 1'b0, 32'h0000_005A, 4'b0000);
    directed("sbc",    32'h0000_0000, 32'h0000_0001, 4'b0101, 1'b1, 32'hFFFF_FFFE, 4'b1010);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 1'b0, 32'h8000_0000, 4'b1001);
    directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 4'b0100, 1'b0, 32'h7FFF_FFFF, 4'b0001);
    directed("rsb",    32'h0000_0005, 32'h0000_0003, 4'b1011, 1'b0, 32'hFFFF_FFFE, 4'b1010);
    directed("and",    32'hFFFF_FFFF, 32'h0000_FFFF, 4'b0110, 1'b0, 32'h0000_FFFF, 4'b0000);
    directed("or",     32'hFFFF_0000, 32'h0000_FFFF, 4'b0111, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    directed("xor",    32'hFFFF_FFFF, 32'h0000_FFFF, 4'b1000, 1'b0, 32'hFFFF_0000, 4'b1000);
    directed("xor_zero", 32'h1234_5678, 32'h1234_5678, 4'b1000, 1'b0, 32'h0, 4'b0100);
    directed("bic",    32'hFFFF_FFFF, 32'h0000_FFFF, 4'b1010, 1'b0, 32'hFFFF_0000, 4'b1000);
`ifdef ALU_SHIFT_EN
    directed("ror",    32'h8000_0001, 32'h0000_0001, 4'b1111, 1'b0, 32'hC000_0000, 4'b1010);
    directed("asr",    32'h8000_0000, 32'h0000_0004, 4'b1110, 1'b0, 32'hF800_0000, 4'b1000);
    directed("lsl",    32'h8000_0001, 32'h0000_0001, 4'b1100, 1'b0, 32'h0000_0002, 4'b0010);
    directed("lsr_sh0", 32'h8000_0001, 32'hFFFF_FFE0, 4'b1101, 1'b0, 32'h8000_0001, 4'b1000);
`else
    directed("reserved", 32'hFFFF_FFFF, 32'h0000_0004, 4'b1100, 1'b1, 32'h0, 4'b0100);
    directed("reserved_f", 32'h1234_5678, 32'h8765_4321, 4'b1111, 1'b0, 32'h0, 4'b0100);
`endif

    for (int i = 0; i < 400; i++) begin
      drive(pick(), pick(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1 check("reset_mid", {r, st}, '0);
        @(posedge clk);
        #1;
        check("reset_mid_held", {r, st}, '0);
        rst_n = 1'b1;
      end
    end

    directed("post_rand_adc", 32'h7FFF_FFFF, 32'h0, 4'b0011, 1'b1, 32'h8000_0000, 4'b1001);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
